// File: rtl/sevenseg_scan.sv
// sevenseg_scan: time-multiplexed driver for NUM_DIGITS common-anode
// 7-segment digits.
// - New values are held in a shadow buffer and are committed only at a
//   frame wrap, so a digit never tears.
// - Each digit slot starts with an optional anode-off interval.
// - Digits decode as hex, or as decimal with values above 9 clamped to 9.
// - Optional leading-zero blanking: define SEVENSEG_LZ_BLANK_EN.
module sevenseg_scan #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 0,
    parameter int unsigned HEX_MODE     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    disp_en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] LAST_P = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] LAST_I = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           r_p;
    logic [IW-1:0]           r_i;
    logic [4*NUM_DIGITS-1:0] r_sh_val;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic [4*NUM_DIGITS-1:0] r_act_val;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic                    r_pend;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic                    r_frame_done;

    logic                    w_slot_end;
    logic                    w_wrap;
    logic                    w_slot_on;
    logic [NUM_DIGITS-1:0]   w_lz_mask;
    logic [3:0]              w_nib;
    logic                    w_dpn;
    logic                    w_lzb;
    logic                    w_on;
    logic [NUM_DIGITS-1:0]   w_an_nxt;

    assign w_slot_end = (r_p == LAST_P);
    assign w_wrap     = w_slot_end && (r_i == LAST_I);

    // Anodes stay off during the first BLANK_CYCLES cycles of each slot.
    generate
        if (BLANK_CYCLES == 0) begin : g_noblank
            assign w_slot_on = 1'b1;
        end else begin : g_blank
            localparam logic [PW-1:0] BLANK_P = PW'(BLANK_CYCLES);
            assign w_slot_on = (r_p >= BLANK_P);
        end
    endgenerate

    // Segment pattern (active low, A..G) for one nibble.
    function automatic logic [6:0] f_decode(input logic [3:0] n);
        logic [3:0] v;
        v = n;
        if (HEX_MODE == 0 && n > 4'd9)
            v = 4'd9;
        case (v)
            4'h0: f_decode = 7'h01;
            4'h1: f_decode = 7'h4F;
            4'h2: f_decode = 7'h12;
            4'h3: f_decode = 7'h06;
            4'h4: f_decode = 7'h4C;
            4'h5: f_decode = 7'h24;
            4'h6: f_decode = 7'h20;
            4'h7: f_decode = 7'h0F;
            4'h8: f_decode = 7'h00;
            4'h9: f_decode = 7'h04;
            4'hA: f_decode = 7'h08;
            4'hB: f_decode = 7'h60;
            4'hC: f_decode = 7'h31;
            4'hD: f_decode = 7'h42;
            4'hE: f_decode = 7'h30;
            default: f_decode = 7'h38;
        endcase
    endfunction

    // Prescaler and digit index; both free-run regardless of disp_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p <= '0;
            r_i <= '0;
        end else if (w_slot_end) begin
            r_p <= '0;
            r_i <= (r_i == LAST_I) ? '0 : r_i + IW'(1);
        end else begin
            r_p <= r_p + PW'(1);
        end
    end

    // Shadow/active buffers: a load on the wrap cycle bypasses the shadow
    // and is committed directly, otherwise it waits for the next wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_val  <= '0;
            r_sh_dp   <= '0;
            r_act_val <= '0;
            r_act_dp  <= '0;
            r_pend    <= 1'b0;
        end else begin
            if (load) begin
                r_sh_val <= value;
                r_sh_dp  <= dp_n;
            end
            if (w_wrap) begin
                if (load) begin
                    r_act_val <= value;
                    r_act_dp  <= dp_n;
                end else if (r_pend) begin
                    r_act_val <= r_sh_val;
                    r_act_dp  <= r_sh_dp;
                end
                r_pend <= 1'b0;
            end else if (load) begin
                r_pend <= 1'b1;
            end
        end
    end

`ifdef SEVENSEG_LZ_BLANK_EN
    logic w_zrun;

    // Leading-zero mask: digit k (k>=1) is blanked when it and all higher
    // nibbles are zero and its decimal point is off.
    always_comb begin
        w_lz_mask = '0;
        w_zrun    = 1'b1;
        for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_zrun       = w_zrun & (r_act_val[4*k +: 4] == 4'h0);
            w_lz_mask[k] = w_zrun & r_act_dp[k];
        end
    end
`else
    assign w_lz_mask = '0;
`endif

    // Select nibble, decimal point and blanking flag of the current digit.
    always_comb begin
        w_nib = '0;
        w_dpn = 1'b1;
        w_lzb = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (r_i == IW'(k)) begin
                w_nib = r_act_val[4*k +: 4];
                w_dpn = r_act_dp[k];
                w_lzb = w_lz_mask[k];
            end
        end
    end

    assign w_on = disp_en && w_slot_on && !w_lzb;

    // Anode pattern for the next cycle: at most one bit low.
    always_comb begin
        w_an_nxt = '1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (w_on && r_i == IW'(k))
                w_an_nxt[k] = 1'b0;
        end
    end

    // Registered pin drivers; segments and dp are forced off whenever no
    // anode is lit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an         <= '1;
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an_nxt;
            r_seg        <= w_on ? f_decode(w_nib) : 7'h7F;
            r_dp         <= w_on ? w_dpn : 1'b1;
            r_frame_done <= w_wrap;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule
